// File: rtl/axis_uart_pkg.sv
// ---------------------------------------------------------------------------
// axis_uart_pkg: shared codes, STATUS layout and state encodings. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package axis_uart_pkg;

  localparam logic [7:0] BYTE_START_DEF = 8'hF0;
  localparam logic [7:0] BYTE_WR_DEF    = 8'hA1;
  localparam logic [7:0] BYTE_RD_DEF    = 8'hA2;

  localparam int STATUS_CHK_ERR_BIT  = 7;
  localparam int STATUS_BAD_CODE_BIT = 6;

  // Largest response body: 4 ADDR + 4 DATA + STATUS + CODE
  localparam int MAX_BODY_BYTES = 10;

  typedef enum logic [2:0] {
    P_START = 3'd0,
    P_ADDR  = 3'd1,
    P_DATA  = 3'd2,
    P_CODE  = 3'd3,
    P_CHK   = 3'd4,
    P_BUSY  = 3'd5
  } parser_state_t;

  typedef enum logic [2:0] {
    E_IDLE   = 3'd0,
    E_DECIDE = 3'd1,
    E_WREQ   = 3'd2,
    E_WWAIT  = 3'd3,
    E_RREQ   = 3'd4,
    E_RWAIT  = 3'd5,
    E_DELAY  = 3'd6,
    E_TX     = 3'd7
  } engine_state_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BODY  = 2'd2,
    S_CHK   = 2'd3
  } ser_state_t;

endpackage

`default_nettype wire

// File: rtl/axis_if.sv
// ---------------------------------------------------------------------------
// axis_if: minimal AXI-Stream byte channel. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface axis_if #(
  parameter int W = 8
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport s_axis (input tdata, input tvalid, output tready);
  modport m_axis (output tdata, output tvalid, input tready);
endinterface

`default_nettype wire

// File: rtl/uart_frame_tx_ser.sv
// ---------------------------------------------------------------------------
// uart_frame_tx_ser: emits START, a loaded body (MSB-first) and its XOR CHK. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_frame_tx_ser
  import axis_uart_pkg::*;
#(
  parameter int         VW         = 8 * MAX_BODY_BYTES,
  parameter logic [7:0] BYTE_START = BYTE_START_DEF
) (
  input  logic          aclk_i,
  input  logic          aresetn_i,
  input  logic          load_i,
  input  logic [VW-1:0] vec_i,
  input  logic [3:0]    len_i,
  output logic          done_o,
  axis_if.m_axis        m_axis
);

  ser_state_t    st_q, st_d;
  logic [VW-1:0] sh_q;
  logic [3:0]    rem_q;
  logic [7:0]    chk_q;

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      st_q <= S_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_IDLE:  if (load_i) st_d = S_START;
      S_START: if (m_axis.tready) st_d = S_BODY;
      S_BODY:  if (m_axis.tready && rem_q == 4'd1) st_d = S_CHK;
      S_CHK:   if (m_axis.tready) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_axis.tvalid = (st_q != S_IDLE);
    m_axis.tdata  = 8'h00;
    done_o        = 1'b0;
    unique case (st_q)
      S_START: m_axis.tdata = BYTE_START;
      S_BODY:  m_axis.tdata = sh_q[VW-1 -: 8];
      S_CHK: begin
        m_axis.tdata = chk_q;
        done_o       = m_axis.tready;
      end
      default: m_axis.tdata = 8'h00;
    endcase
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      rem_q <= 4'd0;
      chk_q <= 8'h00;
    end else if (st_q == S_IDLE && load_i) begin
      rem_q <= len_i;
      chk_q <= 8'h00;
    end else if (st_q == S_BODY && m_axis.tready) begin
      rem_q <= rem_q - 4'd1;
      chk_q <= chk_q ^ sh_q[VW-1 -: 8];
    end
  end

  // Body shifter carries no reset: it is always loaded before it is shown.
  always_ff @(posedge aclk_i) begin
    if (st_q == S_IDLE && load_i) begin
      sh_q <= vec_i;
    end else if (st_q == S_BODY && m_axis.tready) begin
      sh_q <= {sh_q[VW-9:0], 8'h00};
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis_uart_cmd_engine.sv
// ---------------------------------------------------------------------------
// axis_uart_cmd_engine: byte-framed command parser driving a simple bus. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axis_uart_cmd_engine
  import axis_uart_pkg::*;
#(
  parameter int         ADDR_BYTES     = 4,
  parameter int         DATA_BYTES     = 4,
  parameter logic [7:0] BYTE_START     = BYTE_START_DEF,
  parameter logic [7:0] BYTE_WR        = BYTE_WR_DEF,
  parameter logic [7:0] BYTE_RD        = BYTE_RD_DEF,
  parameter int         TIMEOUT_CYCLES = 65535,
  parameter int         RESP_DELAY     = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_done,
  input  logic [1:0]  wr_error,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_addr,
  input  logic [31:0] rd_data,
  input  logic        rd_done,
  input  logic [1:0]  rd_error,
  axis_if.s_axis      s_axis,
  axis_if.m_axis      m_axis
);

  localparam int          VW        = 8 * MAX_BODY_BYTES;
  localparam logic [2:0]  ADDR_LAST = 3'(ADDR_BYTES - 1);
  localparam logic [2:0]  DATA_LAST = 3'(DATA_BYTES - 1);
  localparam logic [31:0] TO_LAST   = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  localparam logic [31:0] DLY_LAST  = (RESP_DELAY > 0) ? 32'(RESP_DELAY - 1) : 32'd0;
  localparam logic [3:0]  RESP_LEN  = 4'(ADDR_BYTES + DATA_BYTES + 2);
  localparam engine_state_t E_AFTER = (RESP_DELAY == 0) ? E_TX : E_DELAY;

  parser_state_t ps_q, ps_d;
  engine_state_t es_q, es_d;
  logic          run_q;
  logic [2:0]    cnt_q;
  logic [31:0]   to_q;
  logic [31:0]   dly_q;
  logic [7:0]    chk_q;
  logic          chk_err_q;
  logic [1:0]    err_q;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic [7:0]    code_q;

  logic          w_tready;
  logic          w_acc;
  logic          w_in_frame;
  logic          w_timeout;
  logic          w_bad;
  logic          w_wr_fin;
  logic          w_rd_fin;
  logic          w_load;
  logic          w_ser_done;
  logic [7:0]    w_status;
  logic [VW-1:0] w_vec;

  assign w_acc      = s_axis.tvalid && w_tready;
  assign w_in_frame = (ps_q == P_ADDR) || (ps_q == P_DATA) || (ps_q == P_CODE) || (ps_q == P_CHK);
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && w_in_frame && !w_acc && (to_q == TO_LAST);
  assign w_bad      = !chk_err_q && (code_q != BYTE_WR) && (code_q != BYTE_RD);
  assign w_wr_fin   = ((es_q == E_WREQ) && wr_ready && wr_done) || ((es_q == E_WWAIT) && wr_done);
  assign w_rd_fin   = ((es_q == E_RREQ) && rd_ready && rd_done) || ((es_q == E_RWAIT) && rd_done);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ps_q <= P_START;
      es_q <= E_IDLE;
    end else begin
      ps_q <= ps_d;
      es_q <= es_d;
    end
  end

  always_comb begin
    ps_d = ps_q;
    es_d = es_q;
    unique case (ps_q)
      P_START: if (w_acc && s_axis.tdata == BYTE_START) ps_d = P_ADDR;
      P_ADDR:  if (w_acc && cnt_q == ADDR_LAST) ps_d = P_DATA;
      P_DATA:  if (w_acc && cnt_q == DATA_LAST) ps_d = P_CODE;
      P_CODE:  if (w_acc) ps_d = P_CHK;
      P_CHK: begin
        if (w_acc) begin
          ps_d = P_BUSY;
          es_d = E_DECIDE;
        end
      end
      P_BUSY: begin
        unique case (es_q)
          E_DECIDE: begin
            if (chk_err_q || w_bad) es_d = E_AFTER;
            else if (code_q == BYTE_WR) es_d = E_WREQ;
            else es_d = E_RREQ;
          end
          E_WREQ:  if (wr_ready) es_d = wr_done ? E_AFTER : E_WWAIT;
          E_WWAIT: if (wr_done) es_d = E_AFTER;
          E_RREQ:  if (rd_ready) es_d = rd_done ? E_AFTER : E_RWAIT;
          E_RWAIT: if (rd_done) es_d = E_AFTER;
          E_DELAY: if (dly_q == DLY_LAST) es_d = E_TX;
          E_TX: begin
            if (w_ser_done) begin
              es_d = E_IDLE;
              ps_d = P_START;
            end
          end
          default: begin
            es_d = E_IDLE;
            ps_d = P_START;
          end
        endcase
      end
      default: ps_d = P_START;
    endcase
    if (w_timeout) ps_d = P_START;
  end

  // run_q keeps tready low while aresetn is asserted even though the parser sits in P_START.
  always_comb begin
    w_tready = run_q && (ps_q != P_BUSY);
    wr_valid = (es_q == E_WREQ);
    rd_valid = (es_q == E_RREQ);
    w_load   = (es_q != E_TX) && (es_d == E_TX);
  end

  assign s_axis.tready = w_tready;
  assign wr_addr       = addr_q;
  assign rd_addr       = addr_q;
  assign wr_data       = data_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_q     <= 1'b0;
      cnt_q     <= 3'd0;
      to_q      <= 32'd0;
      dly_q     <= 32'd0;
      chk_q     <= 8'h00;
      chk_err_q <= 1'b0;
      err_q     <= 2'b00;
    end else begin
      run_q <= 1'b1;
      to_q  <= (w_in_frame && !w_acc && !w_timeout) ? to_q + 32'd1 : 32'd0;
      dly_q <= (es_q == E_DELAY) ? dly_q + 32'd1 : 32'd0;
      if (w_timeout) cnt_q <= 3'd0;
      if (w_acc) begin
        unique case (ps_q)
          P_START: begin
            cnt_q <= 3'd0;
            chk_q <= 8'h00;
            err_q <= 2'b00;
          end
          P_ADDR: begin
            cnt_q <= (cnt_q == ADDR_LAST) ? 3'd0 : cnt_q + 3'd1;
            chk_q <= chk_q ^ s_axis.tdata;
          end
          P_DATA: begin
            cnt_q <= (cnt_q == DATA_LAST) ? 3'd0 : cnt_q + 3'd1;
            chk_q <= chk_q ^ s_axis.tdata;
          end
          P_CODE:  chk_q <= chk_q ^ s_axis.tdata;
          P_CHK:   chk_err_q <= (s_axis.tdata != chk_q);
          default: cnt_q <= 3'd0;
        endcase
      end
      if (w_wr_fin) err_q <= wr_error;
      if (w_rd_fin) err_q <= rd_error;
    end
  end

  // Address/data are cleared on START so narrow frames zero-extend naturally.
  always_ff @(posedge aclk) begin
    if (w_acc && ps_q == P_START) begin
      addr_q <= 32'd0;
      data_q <= 32'd0;
    end
    if (w_acc && ps_q == P_ADDR) addr_q <= {addr_q[23:0], s_axis.tdata};
    if (w_acc && ps_q == P_DATA) data_q <= {data_q[23:0], s_axis.tdata};
    if (w_acc && ps_q == P_CODE) code_q <= s_axis.tdata;
    if (w_rd_fin) data_q <= rd_data;
  end

  always_comb begin
    w_status                      = 8'h00;
    w_status[STATUS_CHK_ERR_BIT]  = chk_err_q;
    w_status[STATUS_BAD_CODE_BIT] = w_bad;
    w_status[1:0]                 = err_q;
    w_vec = '0;
    w_vec[VW-1 -: 8*ADDR_BYTES]                              = addr_q[8*ADDR_BYTES-1:0];
    w_vec[VW-1-8*ADDR_BYTES -: 8*DATA_BYTES]                 = data_q[8*DATA_BYTES-1:0];
    w_vec[VW-1-8*(ADDR_BYTES+DATA_BYTES) -: 8]               = w_status;
    w_vec[VW-9-8*(ADDR_BYTES+DATA_BYTES) -: 8]               = code_q;
  end

  uart_frame_tx_ser #(
    .VW         (VW),
    .BYTE_START (BYTE_START)
  ) u_ser (
    .aclk_i    (aclk),
    .aresetn_i (aresetn),
    .load_i    (w_load),
    .vec_i     (w_vec),
    .len_i     (RESP_LEN),
    .done_o    (w_ser_done),
    .m_axis    (m_axis)
  );

endmodule

`default_nettype wire
